// File: rtl/seq_multiplier_param_if.sv
// Request/response bundle for seq_multiplier_param.
// signed_mode exists only when MULT_SIGNED_EN is defined.
interface seq_multiplier_param_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
`ifdef MULT_SIGNED_EN
  logic                 signed_mode;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
`ifdef MULT_SIGNED_EN
    output signed_mode,
`endif
    output start,
    output multiplier,
    output multiplicand,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
`ifdef MULT_SIGNED_EN
    input  signed_mode,
`endif
    input  start,
    input  multiplier,
    input  multiplicand,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/seq_multiplier_param.sv
// Shift-add sequential multiplier, one partial product per clock.
// Optional two's-complement mode: define MULT_SIGNED_EN.
module seq_multiplier_param #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  seq_multiplier_param_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a_ld, b_ld;
  logic [PW-1:0]    res;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;

  // Magnitudes go through the unsigned core; sign is restored at the end.
  assign a_neg = bus.signed_mode & bus.multiplier[WIDTH-1];
  assign b_neg = bus.signed_mode & bus.multiplicand[WIDTH-1];
  assign a_ld  = a_neg ? -bus.multiplier : bus.multiplier;
  assign b_ld  = b_neg ? -bus.multiplicand : bus.multiplicand;
  assign res   = neg_q ? -acc_q : acc_q;
`else
  assign a_ld = bus.multiplier;
  assign b_ld = bus.multiplicand;
  assign res  = acc_q;
`endif

  // Carry out of the upper half is shifted back into the accumulator.
  assign sum = {1'b0, acc_q[PW-1:WIDTH]}
             + {1'b0, (mr_q[0] ? md_q : '0)};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mr_d    = mr_q;
    md_d    = md_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
`ifdef MULT_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mr_d    = a_ld;
          md_d    = b_ld;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef MULT_SIGNED_EN
          neg_d   = a_neg ^ b_neg;
`endif
        end
      end
      CALC: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        mr_d  = mr_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        prod_d  = res;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mr_q    <= '0;
      md_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mr_q    <= mr_d;
      md_q    <= md_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

`ifdef MULT_SIGNED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`endif

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = prod_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed and random checks of seq_multiplier_param at WIDTH 4, 8, 6.
// Signed vectors run only when MULT_SIGNED_EN is defined.
module tb_seq_multiplier_param;

  logic clk;
  logic rst;

  int n_chk;
  int n_fail;

  seq_multiplier_param_if #(.WIDTH(4)) if4 ();
  seq_multiplier_param_if #(.WIDTH(8)) if8 ();
  seq_multiplier_param_if #(.WIDTH(6)) if6 ();

  seq_multiplier_param #(.WIDTH(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  seq_multiplier_param #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  seq_multiplier_param #(.WIDTH(6)) u6 (
    .clk (clk),
    .rst (rst),
    .bus (if6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic op4(input logic [3:0] a,
                     input logic [3:0] b,
                     input logic sm,
                     output logic [7:0] p,
                     output int lat,
                     output int nbusy);
    logic [7:0] prev;
    prev = if4.product;
    if4.start = 1'b1;
    if4.multiplier = a;
    if4.multiplicand = b;
`ifdef MULT_SIGNED_EN
    if4.signed_mode = sm;
`endif
    lat = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if4.start = 1'b0;
        if4.multiplier = 4'($urandom);
        if4.multiplicand = 4'($urandom);
`ifdef MULT_SIGNED_EN
        if4.signed_mode = ~sm;
`endif
      end
      if (if4.busy) nbusy++;
      if (!if4.done) chk("hold4", 64'(if4.product), 64'(prev));
    end while (!if4.done && lat < 40);
    p = if4.product;
  endtask

  task automatic op8(input logic [7:0] a,
                     input logic [7:0] b,
                     output logic [15:0] p,
                     output int lat);
    logic [15:0] prev;
    prev = if8.product;
    if8.start = 1'b1;
    if8.multiplier = a;
    if8.multiplicand = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) if8.start = 1'b0;
      if (!if8.done) chk("hold8", 64'(if8.product), 64'(prev));
    end while (!if8.done && lat < 40);
    p = if8.product;
  endtask

  task automatic op6(input logic [5:0] a,
                     input logic [5:0] b,
                     output logic [11:0] p,
                     output int lat);
    if6.start = 1'b1;
    if6.multiplier = a;
    if6.multiplicand = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if6.start = 1'b0;
        if6.multiplier = 6'($urandom);
        if6.multiplicand = 6'($urandom);
      end
    end while (!if6.done && lat < 40);
    p = if6.product;
  endtask

  initial begin
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [11:0] p6;
    logic [5:0]  ra, rb;
    int lat, nb, nd, first;

    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    if4.start = 1'b0; if4.multiplier = '0; if4.multiplicand = '0;
    if8.start = 1'b0; if8.multiplier = '0; if8.multiplicand = '0;
    if6.start = 1'b0; if6.multiplier = '0; if6.multiplicand = '0;
`ifdef MULT_SIGNED_EN
    if4.signed_mode = 1'b0;
    if8.signed_mode = 1'b0;
    if6.signed_mode = 1'b0;
`endif

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(if4.busy), 64'd0);
    chk("rst_done", 64'(if4.done), 64'd0);
    chk("rst_prod4", 64'(if4.product), 64'd0);
    chk("rst_prod8", 64'(if8.product), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 13*11
    op4(4'd13, 4'd11, 1'b0, p4, lat, nb);
    chk("t1_prod", 64'(p4), 64'h8F);
    chk("t1_lat", 64'(lat), 64'd6);
    chk("t1_busy", 64'(nb), 64'd5);
    @(negedge clk);
    chk("t1_pulse", 64'(if4.done), 64'd0);

    // 3*5 with an ignored 15*15 request during CALC
    if4.start = 1'b1; if4.multiplier = 4'd3; if4.multiplicand = 4'd5;
    nd = 0; nb = 0; first = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) if4.start = 1'b0;
      if (c == 2) begin
        if4.start = 1'b1; if4.multiplier = 4'd15; if4.multiplicand = 4'd15;
      end
      if (c == 3) if4.start = 1'b0;
      if (if4.busy) nb++;
      if (if4.done) begin
        nd++;
        if (first == 0) first = c;
      end
    end
    chk("t3_ndone", 64'(nd), 64'd1);
    chk("t3_lat", 64'(first), 64'd6);
    chk("t3_busy", 64'(nb), 64'd5);
    chk("t3_prod", 64'(if4.product), 64'd15);

    // 9*9 aborted by reset two cycles into CALC
    if4.start = 1'b1; if4.multiplier = 4'd9; if4.multiplicand = 4'd9;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_busy", 64'(if4.busy), 64'd0);
    chk("t4_prod", 64'(if4.product), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (if4.done) nd++;
    end
    chk("t4_nodone", 64'(nd), 64'd0);
    op4(4'd2, 4'd7, 1'b0, p4, lat, nb);
    chk("t4_after", 64'(p4), 64'd14);

    // 255*255 then back-to-back 0*200
    op8(8'd255, 8'd255, p8, lat);
    chk("t2_prod_a", 64'(p8), 64'hFE01);
    chk("t2_lat_a", 64'(lat), 64'd10);
    op8(8'd0, 8'd200, p8, lat);
    chk("t2_prod_b", 64'(p8), 64'h0);
    chk("t2_lat_b", 64'(lat), 64'd10);

    // Random unsigned sweep at WIDTH=6
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 6'($urandom);
      rb = 6'($urandom);
      op6(ra, rb, p6, lat);
      chk("t6_prod", 64'(p6), 64'(12'(ra) * 12'(rb)));
      chk("t6_lat", 64'(lat), 64'd8);
    end

`ifdef MULT_SIGNED_EN
    @(negedge clk);
    op4(4'hD, 4'h5, 1'b1, p4, lat, nb);
    chk("t5_m3x5", 64'(p4), 64'hF1);
    chk("t5_lat", 64'(lat), 64'd6);
    op4(4'h8, 4'h8, 1'b1, p4, lat, nb);
    chk("t5_m8xm8", 64'(p4), 64'h40);
    op4(4'hD, 4'h5, 1'b0, p4, lat, nb);
    chk("t5_uns", 64'(p4), 64'h41);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
